// File: rtl/sam_pkg.sv
// ============================================================================
// Module      : sam_pkg
// Description : Shared types and field helpers for the SAM accumulator core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sam_pkg;

    localparam int unsigned c_OPC_W = 4;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LDI    = 4'h1,
        OP_LD     = 4'h2,
        OP_LDN    = 4'h3,
        OP_ST     = 4'h4,
        OP_STN    = 4'h5,
        OP_ADD    = 4'h6,
        OP_SUB    = 4'h7,
        OP_AND    = 4'h8,
        OP_XOR    = 4'h9,
        OP_JMP    = 4'hA,
        OP_JZ     = 4'hB,
        OP_BR     = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_IND    = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    // Opcode occupies the top nibble; the operand is everything below it.
    function automatic int unsigned opc_lsb(input int unsigned data_w);
        return data_w - c_OPC_W;
    endfunction

    function automatic int unsigned opnd_w(input int unsigned data_w);
        return data_w - c_OPC_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sam_alu.sv
// ============================================================================
// Module      : sam_alu
// Description : Combinational ALU (add/sub/and/xor) with carry/borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sam_alu
    import sam_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            ALU_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
            // Borrow is an unsigned compare, independent of the wrapped result.
            ALU_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sam_acc_core.sv
// ============================================================================
// Module      : sam_acc_core
// Description : Accumulator core: fetch/decode/execute sequencer + datapath
//               behind a single req/ack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sam_acc_core
    import sam_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    localparam int unsigned c_OPC_LSB = opc_lsb(DATA_W);
    localparam int unsigned c_OPND_W  = opnd_w(DATA_W);

    state_e              r_state;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_iar;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_use_iar;
    logic                r_req;
    logic                r_we;
    logic                r_z;
    logic                r_c;

    opcode_e             w_op;
    logic [ADDR_W-1:0]   w_t_addr;
    logic [DATA_W-1:0]   w_t_data;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_is_st;
    logic                w_alu_wb;
    alu_op_e             w_alu_op;
    logic [DATA_W-1:0]   w_alu_y;
    logic                w_alu_c;

    assign w_op      = opcode_e'(r_ir[DATA_W-1:c_OPC_LSB]);
    assign w_t_addr  = ADDR_W'(r_ir[c_OPND_W-1:0]);
    assign w_t_data  = DATA_W'(r_ir[c_OPND_W-1:0]);
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_is_st   = (w_op == OP_ST) || (w_op == OP_STN);
    assign w_alu_wb  = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_AND) || (w_op == OP_XOR);

    // A pointer read from memory is widened or narrowed to the address width.
    generate
        if (ADDR_W > DATA_W) begin : g_ptr_ext
            assign w_rd_addr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
        end else begin : g_ptr_trunc
            assign w_rd_addr = mem_rdata[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        w_next_pc = r_pc;
        case (w_op)
            OP_JMP:  w_next_pc = w_t_addr;
            OP_JZ:   if (r_z) w_next_pc = w_t_addr;
            OP_BR:   w_next_pc = r_pc + w_t_addr;
            default: ;
        endcase
    end

    always_comb begin
        w_alu_op = ALU_ADD;
        case (w_op)
            OP_SUB:  w_alu_op = ALU_SUB;
            OP_AND:  w_alu_op = ALU_AND;
            OP_XOR:  w_alu_op = ALU_XOR;
            default: w_alu_op = ALU_ADD;
        endcase
    end

    sam_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a     (r_acc),
        .b     (mem_rdata),
        .op    (w_alu_op),
        .y     (w_alu_y),
        .carry (w_alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_acc     <= '0;
            r_pc      <= '0;
            r_iar     <= '0;
            r_addr    <= '0;
            r_use_iar <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // Only reached with req low straight out of reset.
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_we   <= 1'b0;
                        r_addr <= r_pc;
                    end else if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= w_pc_inc;
                        r_req   <= 1'b0;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_op)
                        OP_HLT: r_state <= ST_HALT;
                        OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                            r_req   <= 1'b1;
                            r_we    <= w_is_st;
                            r_addr  <= w_t_addr;
                            r_state <= ST_MEM;
                        end
                        OP_LDN, OP_STN: begin
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= w_t_addr;
                            r_state <= ST_IND;
                        end
                        default: begin
                            if (w_op == OP_LDI) begin
                                r_acc <= w_t_data;
                                r_z   <= (w_t_data == '0);
                            end
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= w_next_pc;
                            r_state <= ST_FETCH;
                        end
                    endcase
                end
                ST_IND: begin
                    if (mem_ack) begin
                        r_iar     <= w_rd_addr;
                        r_use_iar <= 1'b1;
                        r_we      <= w_is_st;
                        r_state   <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if ((w_op == OP_LD) || (w_op == OP_LDN)) begin
                            r_acc <= mem_rdata;
                            r_z   <= (mem_rdata == '0);
                        end else if (w_alu_wb) begin
                            r_acc <= w_alu_y;
                            r_z   <= (w_alu_y == '0);
                            if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                                r_c <= w_alu_c;
                            end
                        end
                        r_use_iar <= 1'b0;
                        r_req     <= 1'b1;
                        r_we      <= 1'b0;
                        r_addr    <= r_pc;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_HALT: r_req <= 1'b0;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_use_iar ? r_iar : r_addr;
    assign mem_wdata = r_acc;
    assign acc_out   = r_acc;
    assign pc_out    = r_pc;
    assign ir_out    = r_ir;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign halted    = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_sam_acc_core.sv
// ============================================================================
// Module      : tb_sam_acc_core
// Description : Self-checking bench for sam_acc_core (8-bit and 12/10-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sam_acc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, req8, we8, ack8, z8, c8, halt8;
    logic [7:0] addr8, wdata8, rdata8, acc8, pc8, ir8;

    logic        rst12, req12, we12, ack12, z12, c12, halt12;
    logic [9:0]  addr12, pc12;
    logic [11:0] wdata12, rdata12, acc12, ir12;

    logic [7:0]  mem8  [256];
    logic [11:0] mem12 [1024];
    int          nwait = 0;
    int          wcnt  = 0;
    logic        ack_force = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference ISA state
    logic [7:0] m_mem [256];
    int         m_acc, m_pc;
    bit         m_z, m_c, m_halt;

    sam_acc_core #(.DATA_W(8), .ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8), .acc_out(acc8),
        .pc_out(pc8), .ir_out(ir8), .flag_z(z8), .flag_c(c8), .halted(halt8)
    );

    sam_acc_core #(.DATA_W(12), .ADDR_W(10)) dut12 (
        .clk(clk), .rst(rst12), .mem_req(req12), .mem_we(we12), .mem_addr(addr12),
        .mem_wdata(wdata12), .mem_rdata(rdata12), .mem_ack(ack12), .acc_out(acc12),
        .pc_out(pc12), .ir_out(ir12), .flag_z(z12), .flag_c(c12), .halted(halt12)
    );

    // Memory with a programmable number of wait states per access
    assign ack8   = (req8 && (wcnt == nwait)) || ack_force;
    assign rdata8 = mem8[addr8];
    always @(posedge clk) begin
        if (req8 && !ack8) wcnt <= wcnt + 1;
        else               wcnt <= 0;
        if (req8 && ack8 && we8) mem8[addr8] = wdata8;
    end

    assign ack12   = req12;
    assign rdata12 = mem12[addr12];
    always @(posedge clk) begin
        if (req12 && we12) mem12[addr12] = wdata12;
    end

    task automatic clear_mem8();
        for (int i = 0; i < 256; i++) begin
            mem8[i]  = 8'h00;
            m_mem[i] = 8'h00;
        end
    endtask

    // Leaves the bench at the falling edge of the first fetch cycle.
    task automatic reset8();
        bit seen;
        seen      = 1'b0;
        rst8      = 1'b1;
        ack_force = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req8) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset8_fetch_timeout: req=%0b required=1", req8);
        end
    endtask

    task automatic model_step(output int lat);
        int ir, op, t, m, a, s;
        ir   = int'(m_mem[m_pc]);
        m_pc = (m_pc + 1) % 256;
        op   = ir / 16;
        t    = ir % 16;
        m    = int'(m_mem[t]);
        lat  = nwait + 2;
        case (op)
            1:  begin m_acc = t; m_z = (m_acc == 0); end
            2:  begin m_acc = m; m_z = (m_acc == 0); lat += nwait + 1; end
            3:  begin m_acc = int'(m_mem[m]); m_z = (m_acc == 0); lat += 2 * (nwait + 1); end
            4:  begin m_mem[t] = 8'(m_acc); lat += nwait + 1; end
            5:  begin a = m; m_mem[a] = 8'(m_acc); lat += 2 * (nwait + 1); end
            6:  begin s = m_acc + m; m_c = (s > 255); m_acc = s % 256;
                      m_z = (m_acc == 0); lat += nwait + 1; end
            7:  begin m_c = (m_acc < m); m_acc = (m_acc - m + 256) % 256;
                      m_z = (m_acc == 0); lat += nwait + 1; end
            8:  begin m_acc = m_acc & m; m_z = (m_acc == 0); lat += nwait + 1; end
            9:  begin m_acc = m_acc ^ m; m_z = (m_acc == 0); lat += nwait + 1; end
            10: m_pc = t;
            11: if (m_z) m_pc = t;
            12: m_pc = (m_pc + t) % 256;
            15: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        clear_mem8();
        rst8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({acc8, pc8, ir8} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_regs: acc/pc/ir=%h required=000000", {acc8, pc8, ir8});
        end
        n_tests++;
        if ({z8, c8, req8, we8, halt8} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: z,c,req,we,halt=%b required=00000", {z8, c8, req8, we8, halt8});
        end
        reset8();
        n_tests++;
        if (addr8 !== 8'h00 || we8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: addr=%h we=%b required addr=00 we=0", addr8, we8);
        end
    endtask

    task automatic test_add_carry();
        clear_mem8();
        mem8[0] = 8'h15; mem8[1] = 8'h6E; mem8[2] = 8'hF0; mem8[14] = 8'hFB;
        nwait = 0;
        reset8();
        repeat (5) @(negedge clk);
        n_tests++;
        if (acc8 !== 8'h00 || z8 !== 1'b1 || c8 !== 1'b1 || pc8 !== 8'h02) begin
            n_fail++;
            $display("FAIL add_carry: acc=%h z=%b c=%b pc=%h required acc=00 z=1 c=1 pc=02",
                     acc8, z8, c8, pc8);
        end
    endtask

    task automatic test_wait_states();
        bit       exp_req;
        bit [7:0] exp_addr;
        clear_mem8();
        mem8[0] = 8'h2A; mem8[1] = 8'hF0; mem8[10] = 8'h3C;
        nwait = 3;
        reset8();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            exp_req  = (k != 4);
            exp_addr = (k < 4) ? 8'h00 : 8'h0A;
            n_tests++;
            if (req8 !== exp_req || we8 !== 1'b0 || (exp_req && addr8 !== exp_addr)) begin
                n_fail++;
                $display("FAIL wait_bus_cycle%0d: req=%b we=%b addr=%h required req=%b we=0 addr=%h",
                         k, req8, we8, addr8, exp_req, exp_addr);
            end
        end
        @(negedge clk);
        n_tests++;
        if (acc8 !== 8'h3C || z8 !== 1'b0 || req8 !== 1'b1 || addr8 !== 8'h01) begin
            n_fail++;
            $display("FAIL wait_ld_result: acc=%h z=%b req=%b addr=%h required acc=3c z=0 req=1 addr=01",
                     acc8, z8, req8, addr8);
        end
        nwait = 0;
    endtask

    task automatic test_indirect();
        clear_mem8();
        mem8[0] = 8'hA8; mem8[8] = 8'h2B; mem8[9] = 8'h52; mem8[10] = 8'hF0;
        mem8[11] = 8'h55; mem8[2] = 8'h80;
        nwait = 0;
        reset8();
        repeat (7) @(negedge clk);
        n_tests++;
        if (req8 !== 1'b1 || we8 !== 1'b0 || addr8 !== 8'h02) begin
            n_fail++;
            $display("FAIL stn_ptr_read: req=%b we=%b addr=%h required req=1 we=0 addr=02", req8, we8, addr8);
        end
        @(negedge clk);
        n_tests++;
        if (req8 !== 1'b1 || we8 !== 1'b1 || addr8 !== 8'h80 || wdata8 !== 8'h55) begin
            n_fail++;
            $display("FAIL stn_write: req=%b we=%b addr=%h wdata=%h required req=1 we=1 addr=80 wdata=55",
                     req8, we8, addr8, wdata8);
        end
        @(negedge clk);
        n_tests++;
        if (mem8[8'h80] !== 8'h55 || addr8 !== 8'h0A || we8 !== 1'b0) begin
            n_fail++;
            $display("FAIL stn_done: M[80]=%h addr=%h we=%b required M[80]=55 addr=0a we=0",
                     mem8[8'h80], addr8, we8);
        end
    endtask

    task automatic test_control();
        bit seen;
        clear_mem8();
        mem8[0] = 8'h10; mem8[1] = 8'hB9;
        reset8();
        repeat (4) @(negedge clk);
        n_tests++;
        if (pc8 !== 8'h09 || addr8 !== 8'h09 || z8 !== 1'b1) begin
            n_fail++;
            $display("FAIL jz_taken: pc=%h addr=%h z=%b required pc=09 addr=09 z=1", pc8, addr8, z8);
        end

        clear_mem8();
        mem8[8'hFE] = 8'hC3;
        reset8();
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (pc8 == 8'hFF) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_tests++;
        if (!seen || pc8 !== 8'h02 || addr8 !== 8'h02) begin
            n_fail++;
            $display("FAIL br_wrap: reached=%b pc=%h addr=%h required reached=1 pc=02 addr=02",
                     seen, pc8, addr8);
        end

        clear_mem8();
        mem8[0] = 8'h11; mem8[1] = 8'h7F; mem8[15] = 8'h02;
        reset8();
        repeat (5) @(negedge clk);
        n_tests++;
        if (acc8 !== 8'hFF || c8 !== 1'b1 || z8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: acc=%h c=%b z=%b required acc=ff c=1 z=0", acc8, c8, z8);
        end
    endtask

    task automatic test_halt();
        int reqs;
        clear_mem8();
        mem8[0] = 8'hF0;
        reset8();
        repeat (2) @(negedge clk);
        n_tests++;
        if (halt8 !== 1'b1 || pc8 !== 8'h01) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b pc=%h required halted=1 pc=01", halt8, pc8);
        end
        reqs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req8 !== 1'b0 || halt8 !== 1'b1) reqs++;
        end
        n_tests++;
        if (reqs != 0) begin
            n_fail++;
            $display("FAIL halt_quiet: bad_cycles=%0d required=0", reqs);
        end

        clear_mem8();
        mem8[0] = 8'h2A; mem8[10] = 8'h3C;
        nwait = 3;
        reset8();
        repeat (6) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8      = 1'b0;
        ack_force = 1'b1;
        n_tests++;
        if (req8 !== 1'b0 || pc8 !== 8'h00 || ir8 !== 8'h00 || acc8 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_mem: req=%b pc=%h ir=%h acc=%h required all 0", req8, pc8, ir8, acc8);
        end
        @(negedge clk);
        ack_force = 1'b0;
        n_tests++;
        if (req8 !== 1'b1 || we8 !== 1'b0 || addr8 !== 8'h00 || ir8 !== 8'h00 || pc8 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_late_ack: req=%b we=%b addr=%h ir=%h pc=%h required req=1 we=0 addr=00 ir=00 pc=00",
                     req8, we8, addr8, ir8, pc8);
        end
        nwait = 0;
    endtask

    task automatic test_random();
        int lat, bad;
        for (int run = 0; run < 6; run++) begin
            nwait = run % 3;
            for (int i = 0; i < 256; i++) begin
                mem8[i]  = 8'($urandom_range(0, 239));
                m_mem[i] = mem8[i];
            end
            m_acc = 0; m_pc = 0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
            reset8();
            for (int n = 0; n < 40; n++) begin
                model_step(lat);
                repeat (lat) @(negedge clk);
                n_tests++;
                if (acc8 !== 8'(m_acc) || pc8 !== 8'(m_pc) || z8 !== m_z || c8 !== m_c ||
                    halt8 !== m_halt || (!m_halt && (req8 !== 1'b1 || addr8 !== 8'(m_pc)))) begin
                    n_fail++;
                    $display("FAIL random_r%0d_i%0d: acc=%h pc=%h z=%b c=%b halt=%b req=%b addr=%h required acc=%h pc=%h z=%b c=%b halt=%b",
                             run, n, acc8, pc8, z8, c8, halt8, req8, addr8,
                             8'(m_acc), 8'(m_pc), m_z, m_c, m_halt);
                end
                if (m_halt) break;
            end
            bad = 0;
            for (int j = 0; j < 256; j++) begin
                if (mem8[j] !== m_mem[j]) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random_r%0d_memory: differing_words=%0d required=0", run, bad);
            end
        end
        nwait = 0;
    endtask

    task automatic test_wide();
        bit seen;
        for (int i = 0; i < 1024; i++) mem12[i] = 12'h000;
        mem12[0] = 12'h1FF; mem12[1] = 12'hAFF; mem12[255] = 12'hCFF;
        rst12 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (acc12 !== 12'h000 || pc12 !== 10'h000 || req12 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_reset: acc=%h pc=%h req=%b required 000 000 0", acc12, pc12, req12);
        end
        rst12 = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req12) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (!seen || acc12 !== 12'h0FF || z12 !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_ldi: started=%b acc=%h z=%b required started=1 acc=0ff z=0", seen, acc12, z12);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (pc12 !== 10'h1FF || addr12 !== 10'h1FF) begin
            n_fail++;
            $display("FAIL wide_branch: pc=%h addr=%h required pc=1ff addr=1ff", pc12, addr12);
        end
    endtask

    initial begin
        rst8  = 1'b1;
        rst12 = 1'b1;
        test_reset();
        test_add_carry();
        test_wait_states();
        test_indirect();
        test_control();
        test_halt();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
